// File: rtl/tournament_chooser_pkg.sv
// Shared types and helpers for the tournament chooser.
// Entry struct uses maximum field widths; unused upper bits stay zero.
package meta_pred_pkg;

  localparam int TAG_MAX = 30;
  localparam int CNT_MAX = 4;
  localparam int IDX_MAX = 32;

  typedef struct packed {
    logic               v;
    logic [TAG_MAX-1:0] tag;
    logic [CNT_MAX-1:0] cnt;
  } chooser_entry_t;

  function automatic logic [CNT_MAX-1:0] cnt_top(
    input int unsigned w
  );
    return CNT_MAX'((1 << w) - 1);
  endfunction

  function automatic logic [CNT_MAX-1:0] sat_inc(
    input logic [CNT_MAX-1:0] c,
    input int unsigned        w
  );
    return (c >= cnt_top(w)) ? cnt_top(w) : c + 1'b1;
  endfunction

  function automatic logic [CNT_MAX-1:0] sat_dec(
    input logic [CNT_MAX-1:0] c
  );
    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [IDX_MAX-1:0] chooser_idx(
    input logic [31:0] pc,
    input logic [31:0] hist,
    input int unsigned n,
    input bit          use_hist
  );
    logic [31:0] m;
    logic [31:0] h;
    m = (32'(1) << n) - 32'(1);
    h = use_hist ? hist : '0;
    return ((pc >> 2) ^ h) & m;
  endfunction

endpackage

// File: rtl/tournament_chooser_if.sv
// IF lookup and EX training signals of the chooser.
// master = pipeline side, slave = chooser side.
interface tournament_chooser_if #(
  parameter int HIST_W = 8
);
  logic [31:0]       pc_if;
  logic              loc_predict_taken_if;
  logic              glob_predict_taken_if;
  logic [HIST_W-1:0] hist_if;
  logic [31:0]       pc_ex;
  logic [HIST_W-1:0] hist_ex;
  logic              is_branch_ex;
  logic              cmp_out_ex;
  logic              loc_predict_taken_ex;
  logic              glob_predict_taken_ex;
  logic              valid_branch;
  logic              predict_taken;
  logic              use_global;
  logic [31:0]       perf_lookups;
  logic [31:0]       perf_pick_wrong;

  modport master (
    output pc_if, loc_predict_taken_if,
    output glob_predict_taken_if,
    output pc_ex, hist_ex, is_branch_ex,
    output cmp_out_ex, loc_predict_taken_ex,
    output glob_predict_taken_ex,
    input  hist_if, valid_branch,
    input  predict_taken, use_global,
    input  perf_lookups, perf_pick_wrong
  );

  modport slave (
    input  pc_if, loc_predict_taken_if,
    input  glob_predict_taken_if,
    input  pc_ex, hist_ex, is_branch_ex,
    input  cmp_out_ex, loc_predict_taken_ex,
    input  glob_predict_taken_ex,
    output hist_if, valid_branch,
    output predict_taken, use_global,
    output perf_lookups, perf_pick_wrong
  );
endinterface

// File: rtl/tournament_chooser_table.sv
// Chooser storage: IF read, EX read, one write via pending register.
// Reads at the pending index see the pending entry (forwarding).
module chooser_table
  import meta_pred_pkg::*;
#(
  parameter int N        = 128,
  parameter int IDX_W    = 7,
  parameter int CNT_INIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IDX_W-1:0] rd_if_idx,
  input  logic [IDX_W-1:0] rd_ex_idx,
  input  logic           we,
  input  logic [IDX_W-1:0] wr_idx,
  input  chooser_entry_t wr_entry,
  output chooser_entry_t rd_if,
  output chooser_entry_t rd_ex
);

  chooser_entry_t mem [N];
  logic           pend_v;
  logic [IDX_W-1:0] pend_idx;
  chooser_entry_t pend;

  // Pending-write register; an update in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_v   <= 1'b0;
      pend_idx <= '0;
      pend     <= '0;
    end else begin
      pend_v   <= we;
      pend_idx <= wr_idx;
      pend     <= wr_entry;
    end
  end

  // Table array: cleared on reset, written one edge after capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '{v: 1'b0, tag: '0,
                    cnt: CNT_MAX'(CNT_INIT)};
      end
    end else if (pend_v) begin
      mem[pend_idx] <= pend;
    end
  end

  // Read ports with forwarding from the pending write.
  always_comb begin
    rd_if = mem[rd_if_idx];
    rd_ex = mem[rd_ex_idx];
    if (pend_v && pend_idx == rd_if_idx) rd_if = pend;
    if (pend_v && pend_idx == rd_ex_idx) rd_ex = pend;
  end

endmodule

// File: rtl/tournament_chooser.sv
// Tournament chooser top: selects local vs global direction per branch.
// Optional perf counters enabled by defining META_PERF_EN.
module tournament_chooser
  import meta_pred_pkg::*;
#(
  parameter int N        = 128,
  parameter int CNT_W    = 2,
  parameter int TAG_W    = 32 - $clog2(N) - 2,
  parameter int CNT_INIT = 1,
  parameter int USE_HIST = 0,
  parameter int HIST_W   = 8
) (
  input logic clk,
  input logic rst,
  tournament_chooser_if.slave bus
);

  localparam int IDX_W = $clog2(N);

  logic [HIST_W-1:0]  hist;
  logic [IDX_W-1:0]   idx_if;
  logic [IDX_W-1:0]   idx_ex;
  logic [TAG_MAX-1:0] tag_if;
  logic [TAG_MAX-1:0] tag_ex;
  chooser_entry_t     rd_if;
  chooser_entry_t     rd_ex;
  chooser_entry_t     wr_entry;
  logic [CNT_MAX-1:0] base;
  logic [CNT_MAX-1:0] nxt;
  logic               gc;
  logic               lc;
  logic               hit_ex;
  logic               pick_wrong;

  assign idx_if = IDX_W'(chooser_idx(bus.pc_if,
                    32'(bus.hist_if), IDX_W, USE_HIST != 0));
  assign idx_ex = IDX_W'(chooser_idx(bus.pc_ex,
                    32'(bus.hist_ex), IDX_W, USE_HIST != 0));
  assign tag_if = TAG_MAX'(bus.pc_if[IDX_W+2 +: TAG_W]);
  assign tag_ex = TAG_MAX'(bus.pc_ex[IDX_W+2 +: TAG_W]);

  chooser_table #(
    .N        (N),
    .IDX_W    (IDX_W),
    .CNT_INIT (CNT_INIT)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .rd_if_idx (idx_if),
    .rd_ex_idx (idx_ex),
    .we        (bus.is_branch_ex),
    .wr_idx    (idx_ex),
    .wr_entry  (wr_entry),
    .rd_if     (rd_if),
    .rd_ex     (rd_ex)
  );

  assign bus.valid_branch  = rd_if.v && (rd_if.tag == tag_if);
  assign bus.use_global    = rd_if.cnt[CNT_W-1];
  assign bus.predict_taken = bus.use_global
                             ? bus.glob_predict_taken_if
                             : bus.loc_predict_taken_if;
  assign bus.hist_if       = hist;

  // Training rule: move toward whichever predictor alone was right.
  always_comb begin
    hit_ex = rd_ex.v && (rd_ex.tag == tag_ex);
    base   = hit_ex ? rd_ex.cnt : CNT_MAX'(CNT_INIT);
    gc     = bus.glob_predict_taken_ex == bus.cmp_out_ex;
    lc     = bus.loc_predict_taken_ex == bus.cmp_out_ex;
    nxt    = base;
    if (gc && !lc) nxt = sat_inc(base, CNT_W);
    if (!gc && lc) nxt = sat_dec(base);
    wr_entry = '{v: 1'b1, tag: tag_ex, cnt: nxt};
    pick_wrong = rd_ex.cnt[CNT_W-1] ? (!gc && lc)
                                    : (gc && !lc);
  end

  // Non-speculative outcome history, updated at resolution.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist <= '0;
    end else if (bus.is_branch_ex) begin
      hist <= HIST_W'({hist, bus.cmp_out_ex});
    end
  end

`ifdef META_PERF_EN
  logic [31:0] lookups;
  logic [31:0] wrong;

  // Perf counters: trained branches and wrong chooser picks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lookups <= '0;
      wrong   <= '0;
    end else if (bus.is_branch_ex) begin
      lookups <= lookups + 32'd1;
      if (pick_wrong) wrong <= wrong + 32'd1;
    end
  end

  assign bus.perf_lookups    = lookups;
  assign bus.perf_pick_wrong = wrong;
`else
  assign bus.perf_lookups    = '0;
  assign bus.perf_pick_wrong = '0;
  logic unused_perf;
  assign unused_perf = pick_wrong;
`endif

endmodule
